// File: rtl/spm_hs_pkg.sv
// rtl/spm_hs_pkg.sv - shared state encoding and sizing helpers for spm_hs
package spm_hs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // the step counter must reach N+1, one past the last serial bit
  function automatic int cnt_w(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// rtl/spm_csa_cell.sv - bit-serial carry-save adder cell with local sum and carry flops
module spm_csa_cell #(
  parameter bit TOP = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic sin,
  output logic sout
);

  logic       c;
  logic       fb;
  logic [1:0] f;

  // the two's-complement top cell re-reads its own sum: arithmetic shift keeps the sign
  assign fb = TOP ? sout : sin;
  assign f  = {1'b0, a} + {1'b0, fb} + {1'b0, c};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sout <= 1'b0;
      c    <= 1'b0;
    end else if (clr) begin
      sout <= 1'b0;
      c    <= 1'b0;
    end else if (en) begin
      sout <= f[0];
      c    <= f[1];
    end
  end

endmodule

// File: rtl/spm_hs.sv
// rtl/spm_hs.sv - handshaked serial-parallel multiplier, signed or unsigned per operation
module spm_hs
  import spm_hs_pkg::*;
#(
  parameter int XW = 32,
  parameter int YW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XW-1:0]   x,
  input  logic [YW-1:0]   y,
  input  logic            is_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XW+YW-1:0] p,
  output logic            busy
);

  localparam int N  = XW + YW;
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] NC = CW'(N);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XW:0]     xr;
  logic [YW-1:0]   ysh;
  logic            sgn;
  logic [N-1:0]    res;
  logic [XW:0]     a;
  logic [XW:0]     s;
  logic            accept;
  logic            step;

  assign accept = (state == IDLE) && in_valid;
  assign step   = (state == CALC) && (cnt < NC);
  assign a      = xr & {(XW + 1){ysh[0]}};
  assign p      = res;

  genvar i;
  for (i = 0; i < XW; i++) begin : g_cell
    spm_csa_cell #(.TOP(1'b0)) u_cell (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (step),
      .a    (a[i]),
      .sin  (s[i+1]),
      .sout (s[i])
    );
  end

  spm_csa_cell #(.TOP(1'b1)) u_top (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (step),
    .a    (a[XW]),
    .sin  (1'b0),
    .sout (s[XW])
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      xr        <= '0;
      ysh       <= '0;
      sgn       <= 1'b0;
      res       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr       <= {is_signed & x[XW-1], x};
            ysh      <= y;
            sgn      <= is_signed;
            res      <= '0;
            cnt      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          // y shifts out LSB first; past its width it repeats the sign bit or feeds zeros
          if (cnt < NC)
            ysh <= {sgn & ysh[YW-1], ysh[YW-1:1]};
          // the registered LSB sum lags the step by one edge
          if (cnt != '0)
            res <= {s[0], res[N-1:1]};
          if (cnt == NC) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_hs.sv
// tb/tb_spm_hs.sv - self-checking bench for spm_hs at 8x8, 13x5 and 32x16
module tb_spm_hs;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic        ivd [3];
  logic        sgd [3];
  logic        ord [3];
  logic        irw [3];
  logic        ovw [3];
  logic        bsw [3];
  logic [63:0] pw  [3];
  int          xws [3];
  int          yws [3];

  logic [7:0]  a_x, a_y;
  logic [15:0] a_p;
  logic        a_ir, a_ov, a_bs;
  logic [12:0] b_x;
  logic [4:0]  b_y;
  logic [17:0] b_p;
  logic        b_ir, b_ov, b_bs;
  logic [31:0] c_x;
  logic [15:0] c_y;
  logic [47:0] c_p;
  logic        c_ir, c_ov, c_bs;

  spm_hs #(.XW(8), .YW(8)) u_a (
    .clk(clk), .rst(rst_n), .in_valid(ivd[0]), .in_ready(a_ir), .x(a_x), .y(a_y),
    .is_signed(sgd[0]), .out_valid(a_ov), .out_ready(ord[0]), .p(a_p), .busy(a_bs)
  );
  spm_hs #(.XW(13), .YW(5)) u_b (
    .clk(clk), .rst(rst_n), .in_valid(ivd[1]), .in_ready(b_ir), .x(b_x), .y(b_y),
    .is_signed(sgd[1]), .out_valid(b_ov), .out_ready(ord[1]), .p(b_p), .busy(b_bs)
  );
  spm_hs #(.XW(32), .YW(16)) u_c (
    .clk(clk), .rst(rst_n), .in_valid(ivd[2]), .in_ready(c_ir), .x(c_x), .y(c_y),
    .is_signed(sgd[2]), .out_valid(c_ov), .out_ready(ord[2]), .p(c_p), .busy(c_bs)
  );

  assign irw[0] = a_ir;  assign ovw[0] = a_ov;  assign bsw[0] = a_bs;  assign pw[0] = {48'd0, a_p};
  assign irw[1] = b_ir;  assign ovw[1] = b_ov;  assign bsw[1] = b_bs;  assign pw[1] = {46'd0, b_p};
  assign irw[2] = c_ir;  assign ovw[2] = c_ov;  assign bsw[2] = c_bs;  assign pw[2] = {16'd0, c_p};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // product of the operands read as integers in the chosen mode, reduced mod 2^(xw+yw)
  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input int xw, input int yw, input bit s);
    longint xv, yv, pv;
    logic [63:0] m;
    xv = longint'(x);
    yv = longint'(y);
    if (s && x[xw-1]) xv = xv - (longint'(1) << xw);
    if (s && y[yw-1]) yv = yv - (longint'(1) << yw);
    pv = xv * yv;
    m  = (64'd1 << (xw + yw)) - 64'd1;
    return 64'(pv) & m;
  endfunction

  function automatic logic [63:0] rnd(input int w);
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic drive(input int k, input bit v, input logic [63:0] x, input logic [63:0] y, input bit s);
    ivd[k] = v;
    sgd[k] = s;
    case (k)
      0: begin a_x = x[7:0];  a_y = y[7:0];  end
      1: begin b_x = x[12:0]; b_y = y[4:0];  end
      default: begin c_x = x[31:0]; c_y = y[15:0]; end
    endcase
  endtask

  // accept one operation, optionally add noise on the inputs, and wait for out_valid
  task automatic start_op(input int k, input logic [63:0] x, input logic [63:0] y, input bit s,
                          input bit noise, output int lat);
    int t;
    t = 0;
    while (!irw[k] && t < 200) begin
      @(posedge clk); #1; t++;
    end
    drive(k, 1'b1, x, y, s);
    @(posedge clk); #1;
    drive(k, 1'b0, rnd(64), rnd(64), 1'b0);
    lat = 0;
    do begin
      if (noise) drive(k, 1'($urandom), rnd(64), rnd(64), 1'($urandom));
      @(posedge clk); #1;
      lat++;
    end while (!ovw[k] && lat < 200);
    drive(k, 1'b0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic run_op(input int k, input logic [63:0] x, input logic [63:0] y, input bit s,
                        input int hold, input bit noise, output logic [63:0] pr, output int lat);
    start_op(k, x, y, s, noise, lat);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    ord[k] = 1'b1;
    pr = pw[k];
    @(posedge clk); #1;
    ord[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (irw[k] !== 1'b1 || ovw[k] !== 1'b0 || bsw[k] !== 1'b0 || pw[k] !== 64'd0) begin
        fails++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b busy=%b p=%h, want 1 0 0 0",
                 k, irw[k], ovw[k], bsw[k], pw[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (irw[k] !== 1'b1 || ovw[k] !== 1'b0 || pw[k] !== 64'd0) begin
        fails++;
        $display("FAIL post_reset[%0d]: in_ready=%b out_valid=%b p=%h, want 1 0 0", k, irw[k], ovw[k], pw[k]);
      end
    end
  endtask

  task automatic test_unsigned_max;
    logic [63:0] pr;
    int lat;
    run_op(0, 64'hFF, 64'hFF, 1'b0, 0, 1'b0, pr, lat);
    tests++;
    if (pr !== 64'hFE01) begin
      fails++; $display("FAIL umax_p: got %h want fe01", pr);
    end
    tests++;
    if (lat != 17) begin
      fails++; $display("FAIL umax_latency: got %0d want 17", lat);
    end
    tests++;
    if (ovw[0] !== 1'b0 || irw[0] !== 1'b1) begin
      fails++; $display("FAIL umax_pulse: out_valid=%b in_ready=%b want 0 1", ovw[0], irw[0]);
    end
  endtask

  task automatic test_signed;
    logic [63:0] xs [3];
    logic [63:0] ys [3];
    logic [63:0] ex [3];
    logic [63:0] pr;
    int lat;
    xs = '{64'h80, 64'hFF, 64'h00};
    ys = '{64'h80, 64'h7F, 64'h80};
    ex = '{64'h4000, 64'hFF81, 64'h0000};
    for (int i = 0; i < 3; i++) begin
      run_op(0, xs[i], ys[i], 1'b1, 1, 1'b0, pr, lat);
      tests++;
      if (pr !== ex[i] || lat != 17) begin
        fails++;
        $display("FAIL signed[%0d]: got p=%h lat=%0d want p=%h lat=17", i, pr, lat, ex[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] pr;
    int lat;
    start_op(0, 64'd3, 64'd5, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 64'd7, 64'd7, 1'b0);
      tests++;
      if (pw[0] !== 64'h000F || irw[0] !== 1'b0 || ovw[0] !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold[%0d]: p=%h in_ready=%b out_valid=%b want 000f 0 1", i, pw[0], irw[0], ovw[0]);
      end
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
    ord[0] = 1'b1;
    @(posedge clk); #1;
    ord[0] = 1'b0;
    tests++;
    if (ovw[0] !== 1'b0 || irw[0] !== 1'b1 || pw[0] !== 64'h000F) begin
      fails++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b p=%h want 0 1 000f", ovw[0], irw[0], pw[0]);
    end
    run_op(0, 64'd2, 64'd2, 1'b0, 0, 1'b0, pr, lat);
    tests++;
    if (pr !== 64'h0004) begin
      fails++; $display("FAIL bp_next: got %h want 0004", pr);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] pr;
    int t, lat;
    t = 0;
    while (!irw[0] && t < 200) begin
      @(posedge clk); #1; t++;
    end
    drive(0, 1'b1, 64'h12, 64'h34, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (ovw[0] !== 1'b0 || irw[0] !== 1'b1 || pw[0] !== 64'd0 || bsw[0] !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b p=%h busy=%b want 0 1 0 0", ovw[0], irw[0], pw[0], bsw[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 64'h12, 64'h34, 1'b0, 0, 1'b0, pr, lat);
    tests++;
    if (pr !== 64'h03A8 || lat != 17) begin
      fails++; $display("FAIL mid_reset_after: got p=%h lat=%0d want 03a8 17", pr, lat);
    end
  endtask

  task automatic test_wide;
    logic [63:0] pr;
    int lat;
    run_op(2, 64'hFFFF_FFFF, 64'h8000, 1'b1, 0, 1'b0, pr, lat);
    tests++;
    if (pr !== 64'h0000_0000_8000 || lat != 49) begin
      fails++; $display("FAIL wide_signed: got p=%h lat=%0d want 000000008000 49", pr, lat);
    end
    run_op(2, 64'hFFFF_FFFF, 64'h8000, 1'b0, 2, 1'b0, pr, lat);
    tests++;
    if (pr !== 64'h7FFF_FFFF_8000 || lat != 49) begin
      fails++; $display("FAIL wide_unsigned: got p=%h lat=%0d want 7fffffff8000 49", pr, lat);
    end
  endtask

  task automatic test_random(input int k);
    logic [63:0] x, y, pr, ex;
    int lat, nlat;
    bit s;
    nlat = xws[k] + yws[k] + 1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        s = (m == 1);
        x = rnd(xws[k]);
        y = rnd(yws[k]);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        run_op(k, x, y, s, int'($urandom_range(0, 2)), 1'b1, pr, lat);
        ex = model(x, y, xws[k], yws[k], s);
        tests++;
        if (pr !== ex || lat != nlat) begin
          fails++;
          $display("FAIL random[%0d] s=%0d x=%h y=%h: got p=%h lat=%0d want p=%h lat=%0d",
                   k, s, x, y, pr, lat, ex, nlat);
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    xws = '{8, 13, 32};
    yws = '{8, 5, 16};
    for (int k = 0; k < 3; k++) begin
      ord[k] = 1'b0;
      drive(k, 1'b0, 64'd0, 64'd0, 1'b0);
    end
    test_reset;
    test_unsigned_max;
    test_signed;
    test_backpressure;
    test_reset_mid;
    test_wide;
    fork
      test_random(0);
      test_random(1);
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
